// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown sequencer: programmable MM:SS in BCD, 1 Hz countdown,
// alarm with a flashing display once 00:00 is reached.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | time programmable with inc_min/inc_sec, waiting for start
// S_RUN   | counting down one second every TICKS_PER_SEC cycles
// S_PAUSE | time and tick count frozen, start resumes
// S_DONE  | 00:00 reached, alarm high, display flashes
module egg_timer_ctrl #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       inc_min,
  input  logic       inc_sec,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] blank,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int TW = $clog2(TICKS_PER_SEC);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICKS_PER_SEC - 1);
  localparam logic [TW-1:0] FLASH_LAST = TW'(TICKS_PER_SEC / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [15:0]   set_q, set_d;
  logic [15:0]   time_dec;
  logic [TW-1:0] tick_q, tick_d;
  logic [TW-1:0] flash_q, flash_d;
  logic          phase_q, phase_d;
  logic [3:0]    blank_q, blank_d;
  logic          alarm_q, alarm_d;

  function automatic logic [15:0] dec_time(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (t == 16'h0000) begin
      return 16'h0000;
    end
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  function automatic logic [15:0] inc_minutes(input logic [15:0] t);
    logic [3:0] mt, mo;
    {mt, mo} = t[15:8];
    if (mo == 4'd9) begin
      mo = 4'd0;
      mt = (mt == 4'd9) ? 4'd0 : mt + 4'd1;
    end else begin
      mo = mo + 4'd1;
    end
    return {mt, mo, t[7:0]};
  endfunction

  // Seconds wrap 59 -> 00 without touching the minutes.
  function automatic logic [15:0] inc_seconds(input logic [15:0] t);
    logic [3:0] st, so;
    {st, so} = t[7:0];
    if (so == 4'd9) begin
      so = 4'd0;
      st = (st == 4'd5) ? 4'd0 : st + 4'd1;
    end else begin
      so = so + 4'd1;
    end
    return {t[15:8], st, so};
  endfunction

  assign time_dec = dec_time(time_q);

  // tick_q and flash_q are down-counters: cycles left before the terminal count.
  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    set_d   = set_q;
    tick_d  = tick_q;
    flash_d = flash_q;
    phase_d = phase_q;
    alarm_d = alarm_q;
    blank_d = 4'b0000;
    case (state_q)
      S_IDLE: begin
        alarm_d = 1'b0;
        if (clear) begin
          time_d = 16'h0000;
        end else if (start) begin
          if (time_q != 16'h0000) begin
            set_d   = time_q;
            tick_d  = TICK_LAST;
            state_d = S_RUN;
          end
        end else if (inc_min) begin
          time_d = inc_minutes(time_q);
        end else if (inc_sec) begin
          time_d = inc_seconds(time_q);
        end
      end
      S_RUN: begin
        if (clear) begin
          time_d  = 16'h0000;
          tick_d  = TICK_LAST;
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (tick_q == '0) begin
          tick_d = TICK_LAST;
          time_d = time_dec;
          if (time_dec == 16'h0000) begin
            state_d = S_DONE;
            alarm_d = 1'b1;
            flash_d = FLASH_LAST;
            phase_d = 1'b1;
          end
        end else begin
          tick_d = tick_q - TW'(1);
        end
      end
      S_PAUSE: begin
        if (clear) begin
          time_d  = 16'h0000;
          tick_d  = TICK_LAST;
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        // phase_q leads blank_q by one cycle so the display goes dark one edge after entry.
        blank_d = {4{phase_q}};
        if (flash_q == '0) begin
          flash_d = FLASH_LAST;
          phase_d = ~phase_q;
        end else begin
          flash_d = flash_q - TW'(1);
        end
        if (clear) begin
          time_d  = 16'h0000;
          tick_d  = TICK_LAST;
          alarm_d = 1'b0;
          blank_d = 4'b0000;
          state_d = S_IDLE;
        end else if (start) begin
          time_d  = set_q;
          tick_d  = TICK_LAST;
          alarm_d = 1'b0;
          blank_d = 4'b0000;
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      time_q  <= 16'h0000;
      set_q   <= 16'h0000;
      tick_q  <= TICK_LAST;
      flash_q <= FLASH_LAST;
      phase_q <= 1'b1;
      blank_q <= 4'b0000;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      set_q   <= set_d;
      tick_q  <= tick_d;
      flash_q <= flash_d;
      phase_q <= phase_d;
      blank_q <= blank_d;
      alarm_q <= alarm_d;
    end
  end

  assign min_tens = time_q[15:12];
  assign min_ones = time_q[11:8];
  assign sec_tens = time_q[7:4];
  assign sec_ones = time_q[3:0];
  assign blank    = blank_q;
  assign alarm    = alarm_q;
  assign state    = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Directed bench for egg_timer_ctrl with TICKS_PER_SEC = 4: table of
// {pulses, cycles, expected outputs} plus hand sequences for flash and reset.
module tb_egg_timer_ctrl;

  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] ST = 5'b10000;
  localparam logic [4:0] PA = 5'b01000;
  localparam logic [4:0] CL = 5'b00100;
  localparam logic [4:0] IM = 5'b00010;
  localparam logic [4:0] IS = 5'b00001;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct {
    logic [4:0]  in;
    int          n;
    logic [15:0] t;
    logic [1:0]  st;
    logic [3:0]  bl;
    logic        al;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n, start, pause, clear, inc_min, inc_sec;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones, blank;
  logic       alarm;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t tbl_a[$];
  vec_t tbl_b[$];

  egg_timer_ctrl #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .clear(clear),
    .inc_min(inc_min), .inc_sec(inc_sec),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .blank(blank), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] in, input int n, input logic [15:0] t,
                              input logic [1:0] st, input logic [3:0] bl, input logic al);
    vec_t v;
    v.in = in; v.n = n; v.t = t; v.st = st; v.bl = bl; v.al = al;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] et, input logic [1:0] es,
                       input logic [3:0] eb, input logic ea);
    logic [15:0] at;
    at = {min_tens, min_ones, sec_tens, sec_ones};
    n_checks++;
    if ({at, state, blank, alarm} !== {et, es, eb, ea}) begin
      n_fail++;
      $display("FAIL %s: got time=%h state=%0d blank=%b alarm=%b, expected time=%h state=%0d blank=%b alarm=%b",
               nm, at, state, blank, alarm, et, es, eb, ea);
    end
  endtask

  // Called at a negedge: hold the pulses for n rising edges, release, then compare.
  task automatic apply(input logic [4:0] in, input int n);
    {start, pause, clear, inc_min, inc_sec} = in;
    repeat (n) @(negedge clk);
    {start, pause, clear, inc_min, inc_sec} = NO;
  endtask

  task automatic run_tbl(input string tag, input vec_t tbl[$]);
    foreach (tbl[i]) begin
      apply(tbl[i].in, tbl[i].n);
      check($sformatf("%s_row%0d", tag, i), tbl[i].t, tbl[i].st, tbl[i].bl, tbl[i].al);
    end
  endtask

  initial begin
    logic [3:0] exp_flash[5];
    exp_flash = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF};

    // programming, wrap, borrow chain, run to zero
    tbl_a.push_back(mk(IM,           3, 16'h0300, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(IS,          75, 16'h0315, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(IM,          99, 16'h0215, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(CL,           1, 16'h0000, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(ST,           1, 16'h0000, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(IM,          10, 16'h1000, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(ST,           1, 16'h1000, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(NO,           3, 16'h1000, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(NO,           1, 16'h0959, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(NO,           4, 16'h0958, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(ST | PA | CL, 1, 16'h0000, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(IS,          10, 16'h0010, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(ST,           1, 16'h0010, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(NO,           4, 16'h0009, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(CL,           1, 16'h0000, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(IS,           2, 16'h0002, IDLE, 4'h0, 1'b0));
    tbl_a.push_back(mk(ST,           1, 16'h0002, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(NO,           4, 16'h0001, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(NO,           3, 16'h0001, RUN,  4'h0, 1'b0));
    tbl_a.push_back(mk(NO,           1, 16'h0000, DONE, 4'h0, 1'b1));

    // ignored pulses in DONE, restart, pause/resume, pause on terminal tick
    tbl_b.push_back(mk(IM | PA | IS, 1, 16'h0000, DONE,  4'hF, 1'b1));
    tbl_b.push_back(mk(ST,           1, 16'h0002, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(NO,           3, 16'h0002, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(NO,           1, 16'h0001, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(CL,           1, 16'h0000, IDLE,  4'h0, 1'b0));
    tbl_b.push_back(mk(IS,           5, 16'h0005, IDLE,  4'h0, 1'b0));
    tbl_b.push_back(mk(ST,           1, 16'h0005, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(NO,           2, 16'h0005, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(PA,           1, 16'h0005, PAUSE, 4'h0, 1'b0));
    tbl_b.push_back(mk(NO,          20, 16'h0005, PAUSE, 4'h0, 1'b0));
    tbl_b.push_back(mk(ST,           1, 16'h0005, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(NO,           1, 16'h0005, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(NO,           1, 16'h0004, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(NO,           3, 16'h0004, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(PA,           1, 16'h0004, PAUSE, 4'h0, 1'b0));
    tbl_b.push_back(mk(IM | IS,      2, 16'h0004, PAUSE, 4'h0, 1'b0));
    tbl_b.push_back(mk(ST,           1, 16'h0004, RUN,   4'h0, 1'b0));
    tbl_b.push_back(mk(NO,           1, 16'h0003, RUN,   4'h0, 1'b0));

    rst_n = 1'b0;
    {start, pause, clear, inc_min, inc_sec} = NO;
    @(negedge clk);
    repeat (2) @(negedge clk);
    check("reset", 16'h0000, IDLE, 4'h0, 1'b0);
    rst_n = 1'b1;

    run_tbl("a", tbl_a);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("flash%0d", i), 16'h0000, DONE, exp_flash[i], 1'b1);
    end

    run_tbl("b", tbl_b);

    // reset in the middle of a run also wipes the setpoint
    apply(CL, 1);
    apply(IM, 7);
    apply(IS, 30);
    check("set_0730", 16'h0730, IDLE, 4'h0, 1'b0);
    apply(ST, 1);
    apply(NO, 2);
    check("run_0730", 16'h0730, RUN, 4'h0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_reset", 16'h0000, IDLE, 4'h0, 1'b0);
    apply(ST, 1);
    check("start_after_reset", 16'h0000, IDLE, 4'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
